// File: rtl/dramtest_if.sv
// 68030 bus signals between the fill/verify engine (master) and the bus/DRAM side (slave).
// DSACK0/DSACK1 are modelled active-high; nBERR, nBG, nBGACK*, nAS and nDS are active-low.
`timescale 1ns/1ps
interface dramtest_if;
    logic        nBR;
    logic        nBG;
    logic        nBGACK_in;
    logic        nBGACK;
    logic        cpu_nAS;
    logic [31:0] ADDR;
    logic        nAS;
    logic        nDS;
    logic        RnW;
    logic [1:0]  SIZ;
    logic        BUS_OE;
    logic [31:0] DATA_OUT;
    logic        DATA_OE;
    logic [31:0] DATA_IN;
    logic        DSACK0;
    logic        DSACK1;
    logic        nBERR;

    modport master (
        output nBR, nBGACK, ADDR, nAS, nDS, RnW, SIZ, BUS_OE, DATA_OUT, DATA_OE,
        input  nBG, nBGACK_in, cpu_nAS, DATA_IN, DSACK0, DSACK1, nBERR
    );

    modport slave (
        input  nBR, nBGACK, ADDR, nAS, nDS, RnW, SIZ, BUS_OE, DATA_OUT, DATA_OE,
        output nBG, nBGACK_in, cpu_nAS, DATA_IN, DSACK0, DSACK1, nBERR
    );
endinterface

// File: rtl/dramtest.sv
// Boot-time DRAM fill/verify engine: arbitrates for the 68030 bus and runs long-word
// cycles terminated by DSACK, aborting on the first bus error, timeout or data mismatch.
`timescale 1ns/1ps
module dramtest #(
    parameter int unsigned BURST   = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        start,
    input  logic [1:0]  mode,
    input  logic [29:0] base,
    input  logic [23:0] count,
    input  logic [31:0] pattern,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] err_addr,
    output logic [31:0] err_data,
    output logic [3:0]  dbg_state,
    dramtest_if.master  bus
);
    localparam int BW = $clog2(BURST + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        IDLE, REQ, OWN, ADR, STRB, WAIT, CHECK, NEG, WNEG, REL, FIN
    } state_t;

    state_t state, state_n;

    // Synchroniser bit order {cpu_nAS, nBGACK_in, nBG, nBERR, DSACK1, DSACK0}, idle = inactive.
    localparam logic [5:0] SYNC_IDLE = 6'b111100;
    logic [5:0] sync_a, sync_b;
    logic dsack0_s, dsack1_s, nberr_s, nbg_s, nbgack_in_s, cpu_nas_s;

    logic [1:0]    mode_q;
    logic [31:0]   pattern_q;
    logic [29:0]   addr_q;
    logic [23:0]   rem_q;
    logic [BW-1:0] burst_q;
    logic [TW-1:0] tmo_q;
    logic          to_fin_q, to_fin_n;
    logic [31:0]   cur_addr, exp_data;

    logic accept, ld_burst, ld_tmo, dec_tmo, step, abort, mismatch;
    logic owned, on_addr, strobe, wr_drive;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            sync_a <= SYNC_IDLE;
            sync_b <= SYNC_IDLE;
        end else begin
            sync_a <= {bus.cpu_nAS, bus.nBGACK_in, bus.nBG, bus.nBERR, bus.DSACK1, bus.DSACK0};
            sync_b <= sync_a;
        end
    end

    assign dsack0_s    = sync_b[0];
    assign dsack1_s    = sync_b[1];
    assign nberr_s     = sync_b[2];
    assign nbg_s       = sync_b[3];
    assign nbgack_in_s = sync_b[4];
    assign cpu_nas_s   = sync_b[5];

    assign cur_addr  = {addr_q, 2'b00};
    assign exp_data  = mode_q[1] ? cur_addr : pattern_q;
    assign dbg_state = state;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= state_n;
    end

    // start/busy handshake: start is a one-clock request, taken only in IDLE (busy low);
    // it is dropped, not queued, whenever the engine is busy, including the FIN clock.
    always_comb begin
        state_n  = state;
        accept   = 1'b0;
        ld_burst = 1'b0;
        ld_tmo   = 1'b0;
        dec_tmo  = 1'b0;
        step     = 1'b0;
        abort    = 1'b0;
        mismatch = 1'b0;
        to_fin_n = to_fin_q;
        case (state)
            IDLE: if (start) begin
                accept  = 1'b1;
                state_n = (count == 24'd0) ? FIN : REQ;
            end
            REQ:   if (!nbg_s && cpu_nas_s && nbgack_in_s) state_n = OWN;
            OWN: begin
                ld_burst = 1'b1;
                state_n  = ADR;
            end
            ADR:   state_n = STRB;
            STRB: begin
                ld_tmo  = 1'b1;
                state_n = WAIT;
            end
            WAIT: begin
                if (!nberr_s) begin
                    abort   = 1'b1;
                    state_n = NEG;
                end else if (dsack0_s && dsack1_s) begin
                    state_n = CHECK;
                end else if (dsack0_s || dsack1_s || tmo_q == '0) begin
                    abort   = 1'b1;
                    state_n = NEG;
                end else begin
                    dec_tmo = 1'b1;
                end
            end
            CHECK: begin
                mismatch = mode_q[0] && (bus.DATA_IN != exp_data);
                state_n  = NEG;
            end
            NEG:   state_n = WNEG;
            WNEG: if (!dsack0_s && !dsack1_s) begin
                step = 1'b1;
                if (rem_q == 24'd1 || error) begin
                    to_fin_n = 1'b1;
                    state_n  = REL;
                end else if (burst_q == BW'(1)) begin
                    to_fin_n = 1'b0;
                    state_n  = REL;
                end else begin
                    state_n = ADR;
                end
            end
            REL:   state_n = to_fin_q ? FIN : REQ;
            FIN:   state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Bus outputs decode straight from state so reset releases the bus without a clock.
    always_comb begin
        owned    = state inside {OWN, ADR, STRB, WAIT, CHECK, NEG, WNEG};
        on_addr  = state inside {ADR, STRB, WAIT, CHECK, NEG, WNEG};
        strobe   = state inside {STRB, WAIT, CHECK};
        wr_drive = !mode_q[0] && (state inside {ADR, STRB, WAIT, CHECK});

        bus.nBR      = (state != REQ);
        bus.nBGACK   = !owned;
        bus.BUS_OE   = owned;
        bus.ADDR     = on_addr ? cur_addr : 32'd0;
        bus.SIZ      = 2'b00;
        bus.RnW      = on_addr ? mode_q[0] : 1'b1;
        bus.nAS      = !strobe;
        bus.nDS      = !strobe;
        bus.DATA_OE  = wr_drive;
        bus.DATA_OUT = wr_drive ? exp_data : 32'd0;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            mode_q    <= 2'b00;
            pattern_q <= 32'd0;
            addr_q    <= 30'd0;
            rem_q     <= 24'd0;
            burst_q   <= '0;
            tmo_q     <= '0;
            to_fin_q  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            err_addr  <= 32'd0;
            err_data  <= 32'd0;
        end else begin
            to_fin_q <= to_fin_n;
            if (accept) begin
                mode_q    <= mode;
                pattern_q <= pattern;
                addr_q    <= base;
                rem_q     <= count;
                busy      <= 1'b1;
                done      <= 1'b0;
                error     <= 1'b0;
                err_addr  <= 32'd0;
                err_data  <= 32'd0;
            end
            if (ld_burst) burst_q <= BW'(BURST);
            if (ld_tmo)       tmo_q <= TW'(TIMEOUT);
            else if (dec_tmo) tmo_q <= tmo_q - 1'b1;
            if (abort) begin
                error    <= 1'b1;
                err_addr <= cur_addr;
                err_data <= 32'd0;
            end
            if (mismatch) begin
                error    <= 1'b1;
                err_addr <= cur_addr;
                err_data <= bus.DATA_IN;
            end
            // 30-bit address wraps naturally at the top of the long-word space.
            if (step) begin
                addr_q  <= addr_q + 30'd1;
                rem_q   <= rem_q - 24'd1;
                burst_q <= burst_q - 1'b1;
            end
            if (state == FIN) begin
                done <= 1'b1;
                busy <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_dramtest.sv
// Self-checking bench for dramtest: bus arbiter, DSACK/memory responder, bus monitor and
// a transfer-list reference model built from the operation rules.
`timescale 1ns/1ps
module tb_dramtest;
    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [29:0] base = 30'd0;
    logic [23:0] count = 24'd0;
    logic [31:0] pattern = 32'd0;
    logic        busy, done, error;
    logic [31:0] err_addr, err_data;
    logic [3:0]  dbg_state;

    always #10 CLK = ~CLK;

    dramtest_if bus ();
    assign bus.nBGACK_in = bus.nBGACK;
    assign bus.cpu_nAS   = 1'b1;

    dramtest #(.BURST(16), .TIMEOUT(255)) dut (
        .CLK(CLK), .nRST(nRST), .start(start), .mode(mode), .base(base), .count(count),
        .pattern(pattern), .busy(busy), .done(done), .error(error), .err_addr(err_addr),
        .err_data(err_data), .dbg_state(dbg_state), .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Memory seen by reads: default content plus per-long-word overrides.
    logic [31:0] mem_ovr [int unsigned];
    bit          rd_addr_mode = 1'b0;
    logic [31:0] rd_pat = 32'd0;

    function automatic logic [31:0] mem_read(input logic [29:0] a);
        if (mem_ovr.exists(32'(a))) return mem_ovr[32'(a)];
        return rd_addr_mode ? {a, 2'b00} : rd_pat;
    endfunction

    // Responder kinds: 0 normal, 1 BERR on cycle berr_idx, 2 silent, 3 DSACK1 only.
    int rsp_delay = 3;
    int rsp_kind  = 0;
    int berr_idx  = 0;
    int cyc_idx   = 0;

    initial begin
        int wcnt;
        wcnt = 0;
        bus.DSACK0 = 1'b0; bus.DSACK1 = 1'b0; bus.nBERR = 1'b1; bus.DATA_IN = 32'd0;
        forever begin
            @(posedge CLK); #2;
            if (bus.nAS) begin
                bus.DSACK0 = 1'b0; bus.DSACK1 = 1'b0; bus.nBERR = 1'b1; wcnt = 0;
            end else begin
                wcnt++;
                if (wcnt == rsp_delay) begin
                    if (rsp_kind == 3) bus.DSACK1 = 1'b1;
                    else if (rsp_kind == 1 && cyc_idx == berr_idx) bus.nBERR = 1'b0;
                    else if (rsp_kind != 2) begin
                        bus.DSACK0 = 1'b1; bus.DSACK1 = 1'b1;
                        bus.DATA_IN = mem_read(bus.ADDR[31:2]);
                    end
                end
            end
        end
    end

    // Arbiter: grant two clocks after a request, withdraw grant once the request drops.
    initial begin
        int gcnt;
        gcnt = 0;
        bus.nBG = 1'b1;
        forever begin
            @(posedge CLK); #1;
            if (!bus.nBR && bus.nBG) begin
                gcnt++;
                if (gcnt >= 2) begin bus.nBG = 1'b0; gcnt = 0; end
            end else if (bus.nBR && !bus.nBG) begin
                bus.nBG = 1'b1;
            end
        end
    end

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        rnw;
        logic [1:0]  siz;
    } xfer_t;

    xfer_t obs_q[$];
    int    tenure_q[$];
    int    br_falls = 0;
    int    cur_ten  = 0;

    initial begin
        logic        prev_nas, prev_br, prev_bgack, prev_oe;
        logic [31:0] prev_addr;
        prev_nas = 1'b1; prev_br = 1'b1; prev_bgack = 1'b1; prev_oe = 1'b0; prev_addr = 32'd0;
        forever begin
            @(posedge CLK); #1;
            if (prev_nas && !bus.nAS) begin
                chk("addr_setup", bus.ADDR, prev_addr);
                if (!bus.RnW) chk("wdata_setup", {31'd0, prev_oe}, 32'd1);
                obs_q.push_back('{bus.ADDR, bus.DATA_OUT, bus.RnW, bus.SIZ});
                cyc_idx++;
                cur_ten++;
            end
            if (prev_br && !bus.nBR) br_falls++;
            if (!prev_bgack && bus.nBGACK) begin
                tenure_q.push_back(cur_ten);
                cur_ten = 0;
            end
            prev_nas = bus.nAS; prev_br = bus.nBR; prev_bgack = bus.nBGACK;
            prev_oe = bus.DATA_OE; prev_addr = bus.ADDR;
        end
    end

    // Reference model: list of expected transfers, outcome and tenure sizes.
    logic [31:0] exp_q[$];
    logic [31:0] exp_d[$];
    int          exp_ten[$];
    logic        exp_err;
    logic [31:0] exp_eaddr, exp_edata;

    task automatic model_run(input logic [1:0] m, input logic [29:0] b, input logic [23:0] c,
                             input logic [31:0] p);
        int n, rem;
        logic [29:0] a;
        logic [31:0] e, rd;
        exp_q.delete(); exp_d.delete(); exp_ten.delete();
        exp_err = 1'b0; exp_eaddr = 32'd0; exp_edata = 32'd0;
        n = 0;
        for (int i = 0; i < int'(c); i++) begin
            a = b + 30'(i);
            e = m[1] ? {a, 2'b00} : p;
            exp_q.push_back({a, 2'b00});
            exp_d.push_back(e);
            n++;
            if (rsp_kind == 2 || rsp_kind == 3 || (rsp_kind == 1 && n == berr_idx)) begin
                exp_err = 1'b1; exp_eaddr = {a, 2'b00}; exp_edata = 32'd0;
                break;
            end
            if (m[0]) begin
                rd = mem_read(a);
                if (rd != e) begin
                    exp_err = 1'b1; exp_eaddr = {a, 2'b00}; exp_edata = rd;
                    break;
                end
            end
        end
        rem = n;
        while (rem > 0) begin
            exp_ten.push_back(rem > 16 ? 16 : rem);
            rem -= 16;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] m, input logic [29:0] b,
                          input logic [23:0] c, input logic [31:0] p);
        int iters;
        bit seen;
        model_run(m, b, c, p);
        obs_q.delete(); tenure_q.delete();
        br_falls = 0; cyc_idx = 0; cur_ten = 0;
        @(posedge CLK); #1;
        mode = m; base = b; count = c; pattern = p; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        chk({tag, "_done_clr"}, {31'd0, done}, 32'd0);
        if (c != 24'd0) chk({tag, "_nbr_req"}, {31'd0, bus.nBR}, 32'd0);
        iters = 0; seen = 0;
        while (iters < 8000 && !seen) begin
            @(posedge CLK); #1;
            iters++;
            if (done) seen = 1;
        end
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        if (c == 24'd0) chk({tag, "_zero_lat"}, iters, 1);
        chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
        chk({tag, "_error"}, {31'd0, error}, {31'd0, exp_err});
        chk({tag, "_err_addr"}, err_addr, exp_eaddr);
        chk({tag, "_err_data"}, err_data, exp_edata);
        chk({tag, "_released"}, {29'd0, bus.nBR, bus.nBGACK, bus.BUS_OE}, 32'd6);
        chk({tag, "_nxfer"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            chk({tag, "_addr"}, obs_q[i].addr, exp_q[i]);
            chk({tag, "_rnw"}, {31'd0, obs_q[i].rnw}, {31'd0, m[0]});
            chk({tag, "_siz"}, {30'd0, obs_q[i].siz}, 32'd0);
            if (!m[0]) chk({tag, "_wdata"}, obs_q[i].data, exp_d[i]);
        end
        chk({tag, "_ntenure"}, tenure_q.size(), exp_ten.size());
        chk({tag, "_br_falls"}, br_falls, exp_ten.size());
        for (int i = 0; i < tenure_q.size() && i < exp_ten.size(); i++)
            chk({tag, "_tenure"}, tenure_q[i], exp_ten[i]);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  rm;
        logic [29:0] rb, ra;
        logic [23:0] rc;
        logic [31:0] rp;
        int          j, w;

        repeat (3) @(posedge CLK);
        #1;
        chk("rst_strobes", {27'd0, bus.nBR, bus.nBGACK, bus.nAS, bus.nDS, bus.RnW}, 32'h1F);
        chk("rst_oe", {29'd0, bus.SIZ, bus.BUS_OE | bus.DATA_OE}, 32'd0);
        chk("rst_addr", bus.ADDR, 32'd0);
        chk("rst_dout", bus.DATA_OUT, 32'd0);
        chk("rst_status", {29'd0, busy, done, error}, 32'd0);
        chk("rst_err", err_addr | err_data, 32'd0);
        nRST = 1'b1;

        rsp_kind = 0; rsp_delay = 5;
        run_op("fill", 2'b00, 30'h100, 24'd3, 32'hA5A5A5A5);

        rsp_delay = 3; rd_addr_mode = 1'b1;
        mem_ovr[32'd2] = 32'hDEAD0000;
        run_op("vmis", 2'b11, 30'd0, 24'd4, 32'd0);
        mem_ovr.delete();

        run_op("burst", 2'b10, 30'h40, 24'd40, 32'd0);

        rsp_kind = 1; berr_idx = 2;
        run_op("berr", 2'b00, 30'h20, 24'd4, 32'h12345678);
        rsp_kind = 2;
        run_op("tmo", 2'b01, 30'h80, 24'd2, 32'h0);
        rsp_kind = 3;
        run_op("ds1", 2'b00, 30'h90, 24'd2, 32'h0);
        rsp_kind = 0;

        run_op("zero", 2'b00, 30'h10, 24'd0, 32'h0);
        run_op("wrap", 2'b00, 30'h3FFFFFFF, 24'd2, 32'h55AA55AA);

        for (int k = 0; k < 6; k++) begin
            rm = 2'($urandom_range(0, 3));
            rb = 30'($urandom);
            rc = 24'($urandom_range(1, 40));
            rp = $urandom;
            rsp_delay = $urandom_range(1, 6);
            rd_addr_mode = rm[1]; rd_pat = rp;
            mem_ovr.delete();
            if (rm[0] && $urandom_range(0, 1) == 1) begin
                j = $urandom_range(0, int'(rc) - 1);
                ra = rb + 30'(j);
                mem_ovr[32'(ra)] = (rm[1] ? {ra, 2'b00} : rp) ^ (32'($urandom) | 32'h1);
            end
            run_op("rand", rm, rb, rc, rp);
        end
        mem_ovr.delete();

        // Reset while a strobe is low must release the bus immediately.
        rsp_delay = 6;
        @(posedge CLK); #1;
        mode = 2'b00; base = 30'h200; count = 24'd10; pattern = 32'hCAFEF00D; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        w = 0;
        while (w < 200 && bus.nAS) begin @(posedge CLK); #1; w++; end
        chk("midrst_nas_seen", {31'd0, bus.nAS}, 32'd0);
        #3 nRST = 1'b0;
        #1;
        chk("midrst_strobes", {29'd0, bus.nAS, bus.nDS, bus.nBGACK}, 32'd7);
        chk("midrst_oe", {30'd0, bus.BUS_OE, bus.DATA_OE}, 32'd0);
        chk("midrst_status", {29'd0, busy, done, error}, 32'd0);
        repeat (3) @(posedge CLK);
        #1 nRST = 1'b1;
        rsp_delay = 2;
        run_op("after_rst", 2'b10, 30'h300, 24'd5, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
